// File: rtl/lsu_pkg.sv
// Shared encodings for the data-RAM load/store port.
// Covers funct3 codes, the FSM states and the access-size helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Stores only have the three signed encodings; loads add the unsigned pair.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return !ok;
  endfunction

  function automatic size_e f3_size(input logic [2:0] f3);
    size_e sz;
    case (f3[1:0])
      2'b00:   sz = SZ_B;
      2'b01:   sz = SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane/data alignment for the RAM port: builds the 8-lane mask and shifted store
// data across two words, and extracts/extends load data from the {hi,lo} pair.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [7:0]  lane8_o,
  output logic [63:0] data64_o,
  output logic        split_o,
  output logic        illegal_o,
  output logic [31:0] rdata_o
);

  function automatic logic [7:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [7:0] base;
    case (sz)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [63:0] dw);
    logic [31:0] r;
    logic [31:0] res;
    r = 32'(dw >> {off, 3'b000});
    case (f3)
      F3_B:    res = {{24{r[7]}}, r[7:0]};
      F3_H:    res = {{16{r[15]}}, r[15:0]};
      F3_W:    res = r;
      F3_BU:   res = {24'h0, r[7:0]};
      F3_HU:   res = {16'h0, r[15:0]};
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  always_comb begin
    lane8_o   = lane_mask(f3_size(funct3_i), off_i);
    data64_o  = {32'h0, wdata_i} << {off_i, 3'b000};
    split_o   = |lane8_o[7:4];
    illegal_o = f3_illegal(we_i, funct3_i);
    // hi is only meaningful when the access actually reached the second word
    rdata_o   = load_extend(funct3_i, off_i, {(split_o ? hi_i : 32'h0), lo_i});
  end

endmodule

// File: rtl/lsu_ram_port.sv
// Load/store initiator for the word-addressed, byte-masked data RAM; splits
// accesses that straddle a word boundary into two sequential beats.
//
// state | meaning
// IDLE  | ready for a request, RAM idle
// BEAT0 | access word w0 (low lanes)
// BEAT1 | access word w1 = w0+1 (spill-over lanes)
// RESP  | one-cycle completion pulse
module lsu_ram_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_masking,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  state_e            state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] w0_q;
  logic [31:0]       wdata_q;
  logic [31:0]       lo_q;
  logic [31:0]       hi_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [31:0]       wdata_hold_q;

  logic [7:0]        lane8;
  logic [63:0]       data64;
  logic              split;
  logic              illegal;
  logic [31:0]       rdata;
  logic              req_illegal;
  logic              unused_addr_bits;

  assign req_illegal      = f3_illegal(req_we, req_funct3);
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  lsu_align u_align (
    .we_i      (we_q),
    .funct3_i  (f3_q),
    .off_i     (off_q),
    .wdata_i   (wdata_q),
    .lo_i      (lo_q),
    .hi_i      (hi_q),
    .lane8_o   (lane8),
    .data64_o  (data64),
    .split_o   (split),
    .illegal_o (illegal),
    .rdata_o   (rdata)
  );

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = 32'h0;
    mem_w_en       = 1'b0;
    mem_masking    = 4'h0;
    mem_address    = addr_hold_q;
    mem_write_data = wdata_hold_q;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_illegal ? ST_RESP : ST_BEAT0;
      end
      ST_BEAT0: begin
        mem_address    = w0_q;
        mem_masking    = lane8[3:0];
        mem_write_data = data64[31:0];
        mem_w_en       = we_q;
        state_d        = split ? ST_BEAT1 : ST_RESP;
      end
      ST_BEAT1: begin
        mem_address    = w0_q + ADDR_W'(1);
        mem_masking    = lane8[7:4];
        mem_write_data = data64[63:32];
        mem_w_en       = we_q;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = illegal;
        resp_rdata = (we_q || illegal) ? 32'h0 : rdata;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'h0;
      off_q        <= 2'h0;
      w0_q         <= '0;
      wdata_q      <= 32'h0;
      lo_q         <= 32'h0;
      hi_q         <= 32'h0;
      addr_hold_q  <= '0;
      wdata_hold_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      addr_hold_q  <= mem_address;
      wdata_hold_q <= mem_write_data;
      if (state_q == ST_IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        w0_q    <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
      end
      if (state_q == ST_BEAT0 && !we_q) lo_q <= mem_read_data;
      if (state_q == ST_BEAT1 && !we_q) hi_q <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_lsu_ram_port.sv
// Scoreboard bench for lsu_ram_port: a RAM model, directed requests with
// hand-computed beats/responses, and a negedge monitor that pops and compares.
module tb_lsu_ram_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_w_en;
  logic [7:0]  mem_address;
  logic [3:0]  mem_masking;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  lsu_ram_port #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_w_en(mem_w_en), .mem_address(mem_address), .mem_masking(mem_masking),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        we;
  } beat_t;

  resp_t resp_q[$];
  beat_t beat_q[$];
  int    nchk = 0;
  int    nerr = 0;
  int    cyc  = 0;

  bit [31:0]   ram [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h0;
  logic [31:0] pl_data = 32'h0;

  assign mem_read_data = ram[mem_address];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_w_en)
      for (int i = 0; i < 4; i++)
        if (mem_masking[i]) ram[mem_address][8*i +: 8] <= mem_write_data[8*i +: 8];
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_masking != 4'h0 || mem_w_en) begin
        if (beat_q.size() == 0) begin
          check("beat_unexpected", {mem_w_en, 3'b0, mem_masking, 16'h0, mem_address}, 32'h0);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check("beat_addr", {24'h0, mem_address}, {24'h0, b.addr});
          check("beat_mask", {28'h0, mem_masking}, {28'h0, b.mask});
          check("beat_data", mem_write_data, b.data);
          check("beat_we", {31'h0, mem_w_en}, {31'h0, b.we});
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", {31'h0, resp_valid}, 32'h0);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          check("resp_rdata", resp_rdata, r.rdata);
          check("resp_err", {31'h0, resp_err}, {31'h0, r.err});
          check("resp_cycle", cyc, r.cyc);
        end
      end
    end
  end

  task automatic push_beat(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d,
                           input logic we);
    beat_q.push_back('{addr: a, mask: m, data: d, we: we});
  endtask

  // lat: accept edge to the edge that samples resp_valid high
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit exp_resp);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (exp_resp) resp_q.push_back('{rdata: exp_rd, err: exp_err, cyc: cyc + lat - 1});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || beat_q.size() != 0 || !req_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("drain_timeout", resp_q.size() + beat_q.size(), 32'h0);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    drain();
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp,
                    input int lat);
    issue(1'b0, f3, addr, 32'h0, exp, 1'b0, lat, 1'b1);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                    input int lat);
    issue(1'b1, f3, addr, wd, 32'h0, 1'b0, lat, 1'b1);
  endtask

  initial begin
    #2;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp", {resp_valid, resp_err, 30'h0}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_ctl", {mem_w_en, 3'b0, mem_masking, 16'h0, mem_address}, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    push_beat(8'd4, 4'b1111, 32'hDEADBEEF, 1'b1);
    st(3'b010, 32'h10, 32'hDEADBEEF, 2);
    push_beat(8'd4, 4'b1111, 32'h0, 1'b0);
    ld(3'b010, 32'h10, 32'hDEADBEEF, 2);

    preload(8'd4, 32'h80FF1234);
    push_beat(8'd4, 4'b1000, 32'h0, 1'b0);
    ld(3'b000, 32'h13, 32'hFFFFFF80, 2);
    push_beat(8'd4, 4'b0100, 32'h0, 1'b0);
    ld(3'b100, 32'h12, 32'h000000FF, 2);

    preload(8'd4, 32'hAABBCCDD);
    preload(8'd5, 32'h11223344);
    push_beat(8'd4, 4'b1000, 32'h0, 1'b0);
    push_beat(8'd5, 4'b0001, 32'h0, 1'b0);
    ld(3'b101, 32'h13, 32'h000044AA, 3);

    push_beat(8'd255, 4'b1100, 32'h56780000, 1'b1);
    push_beat(8'd0, 4'b0011, 32'h00001234, 1'b1);
    st(3'b010, 32'h3FE, 32'h12345678, 3);
    push_beat(8'd255, 4'b1100, 32'h0, 1'b0);
    push_beat(8'd0, 4'b0011, 32'h0, 1'b0);
    ld(3'b010, 32'h3FE, 32'h12345678, 3);

    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    push_beat(8'd4, 4'b1111, 32'h0, 1'b0);
    ld(3'b010, 32'h10, 32'hAABBCCDD, 2);

    preload(8'd6, 32'h00008001);
    push_beat(8'd6, 4'b0011, 32'h0, 1'b0);
    ld(3'b001, 32'h18, 32'hFFFF8001, 2);
    push_beat(8'd6, 4'b0001, 32'h0, 1'b0);
    ld(3'b000, 32'h18, 32'h00000001, 2);
    push_beat(8'd6, 4'b0100, 32'hFF770000, 1'b1);
    st(3'b000, 32'h1A, 32'hFFFFFF77, 2);
    push_beat(8'd6, 4'b1111, 32'h0, 1'b0);
    ld(3'b010, 32'h18, 32'h00778001, 2);
    push_beat(8'd6, 4'b1000, 32'hCD000000, 1'b1);
    push_beat(8'd7, 4'b0001, 32'h000000AB, 1'b1);
    st(3'b001, 32'h1B, 32'h0000ABCD, 3);
    push_beat(8'd6, 4'b1111, 32'h0, 1'b0);
    ld(3'b010, 32'hFFFFF018, 32'hCD778001, 2);
    push_beat(8'd7, 4'b0001, 32'h0, 1'b0);
    ld(3'b100, 32'h1C, 32'h000000AB, 2);
    push_beat(8'd6, 4'b1100, 32'h0, 1'b0);
    ld(3'b001, 32'h1A, 32'hFFFFCD77, 2);

    // split store aborted by reset while in its second beat
    preload(8'hC0, 32'h11111111);
    drain();
    push_beat(8'hBF, 4'b1000, 32'hD4000000, 1'b1);
    issue(1'b1, 3'b010, 32'h2FF, 32'hA1B2C3D4, 32'h0, 1'b0, 3, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_mem_ctl", {mem_w_en, 3'b0, mem_masking, 16'h0, mem_address}, 32'h0);
    check("abort_mem_wdata", mem_write_data, 32'h0);
    check("abort_req_ready", {31'h0, req_ready}, 32'h1);
    check("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_w1_untouched", ram[8'hC0], 32'h11111111);
    check("abort_w0_written", ram[8'hBF], 32'hD4000000);
    check("abort_beat_q_empty", beat_q.size(), 32'h0);

    push_beat(8'hC0, 4'b1111, 32'h0, 1'b0);
    ld(3'b010, 32'h300, 32'h11111111, 2);

    drain();
    repeat (3) @(negedge clk);
    check("final_resp_q_empty", resp_q.size(), 32'h0);
    check("final_beat_q_empty", beat_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/lsu_ram_port.md
Name: lsu_ram_port

Overview:
Load/store initiator that drives the word-addressed, byte-masked data RAM on behalf of the RV32I core. It converts a core load/store request (byte address, funct3, store data) into RAM address, byte mask and write data, and returns sign- or zero-extended load data. Misaligned accesses that span two words are split into two sequential RAM beats. It sits between the execute stage and the data RAM instance.

Parameters:
ADDR_W, 8, RAM word-address width (RAM depth = 2**ADDR_W words)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  core request valid
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  byte address
req_wdata  in  32  store data (LSB-justified)
resp_valid  out  1  one-cycle completion pulse (loads and stores)
resp_err  out  1  illegal funct3; valid only with resp_valid
resp_rdata  out  32  extended load data; 0 for stores and errors
mem_w_en  out  1  RAM write enable
mem_address  out  ADDR_W  RAM word address
mem_masking  out  4  RAM byte-lane enables
mem_write_data  out  32  RAM write data
mem_read_data  in  32  RAM read data (combinational from mem_address)

Behaviour:
- One clock domain. Reset is asynchronous and active-high. Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_w_en=0, mem_address=0, mem_masking=0, mem_write_data=0.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. When req_valid is high, capture we/funct3/addr/wdata and go to BEAT0. req_ready is 0 in every other state.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other value: skip both beats and go to RESP with resp_err=1. Memory is never written on an error.
- Size: 1, 2 or 4 bytes. off = addr[1:0]. w0 = addr[ADDR_W+1:2]; w1 = w0+1, modulo 2**ADDR_W, so word 255 wraps to word 0. Address bits above ADDR_W+1 are ignored.
- Lane mask: lane8 = base mask (0001, 0011 or 1111) << off, as an 8-bit vector. split = |lane8[7:4].
- Store data: data64 = wdata << (8*off), with wdata zero-extended to 64 bits before the shift.
- BEAT0: mem_address=w0, mem_masking=lane8[3:0], mem_write_data=data64[31:0], mem_w_en=we. For a load, mem_read_data is registered into lo at the clock edge. Next state is BEAT1 if split, otherwise RESP.
- BEAT1: mem_address=w1, mem_masking=lane8[7:4], mem_write_data=data64[63:32], mem_w_en=we. For a load, hi is registered at the clock edge. Next state is RESP.
- Memory outputs in IDLE and RESP: mem_w_en=0, mem_masking=0. mem_address and mem_write_data hold their last values.
- Load result: r = ({hi,lo} >> 8*off), with hi treated as 0 when not split. Take the low byte, halfword or word of r. LB and LH sign-extend; LBU and LHU zero-extend; LW takes r[31:0].
- RESP: resp_valid=1 for exactly one cycle with resp_rdata and resp_err. Then return to IDLE. A request can be accepted the cycle after RESP.
- Latency from accept edge to resp_valid: 2 cycles non-split, 3 cycles split, 1 cycle error.
- Throughput: one request per 3 cycles (aligned) or per 4 cycles (split).
- Reset mid-operation aborts to IDLE immediately. A BEAT0 write already committed stays in memory; the BEAT1 write is not performed. No resp_valid is issued for the aborted request.
- Request inputs are don't-care outside IDLE.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encoding, size encoding.
- Sub-module lsu_align (combinational):
  - funct3 + off + wdata in; lane8 + data64 + split + illegal out.
  - A second function extracts and extends load data from {hi,lo}.
- lsu_ram_port holds the FSM and the capture registers.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF -> one beat: mem_address=4, mask=1111, w_en=1. resp_valid 2 cycles after accept, resp_rdata=0, resp_err=0.
- Word 4 = 0x80FF1234; LB addr 0x13 -> resp_rdata=0xFFFFFF80. LBU addr 0x12 -> 0x000000FF.
- Word 4 = 0xAABBCCDD, word 5 = 0x11223344; LHU addr 0x13 -> two beats (word 4, then word 5), resp_rdata=0x000044AA, resp 3 cycles after accept.
- SW addr 0x3FE, wdata 0x12345678 -> beat0: address 255, mask 1100, data 0x56780000. Beat1: address 0, mask 0011, data 0x00001234.
- req_funct3=011, load or store -> resp_valid 1 cycle after accept with resp_err=1, mem_w_en never asserted.
- Split SW, rst asserted during BEAT1 -> outputs return to reset values at once, word w1 unchanged, no resp_valid. A new LW issued after reset completes normally.
